// File: rtl/id_ex_stage_pkg.sv
// Shared widths, the EX-stage register bundle and the WB bypass helper for id_ex_stage.
// CSR fields appear in the bundle only when ZICSR_EN is defined.
package id_ex_stage_pkg;

   localparam int XLEN       = 32;
   localparam int XADDR      = 5;
   localparam int ALUOP_W    = 4;
   localparam int CSR_ADDR_W = 12;
   localparam int CSR_OP_W   = 3;

   typedef struct packed {
      logic                  valid;
      logic                  rd_wr_en;
      logic                  mem_rd_en;
      logic                  mem_wr_en;
`ifdef ZICSR_EN
      logic                  csr_en;
      logic [CSR_OP_W-1:0]   csr_op;
      logic [CSR_ADDR_W-1:0] csr_addr;
`endif
      logic [ALUOP_W-1:0]    alu_op;
      logic [XADDR-1:0]      rs1_addr;
      logic [XADDR-1:0]      rs2_addr;
      logic [XADDR-1:0]      rd_addr;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       imm;
      logic [XLEN-1:0]       rs1;
      logic [XLEN-1:0]       rs2;
   } ex_regs_t;

   // The register file is written and read on the same edge, so the read port
   // still shows the old value; substitute the value being written back.
   function automatic logic [XLEN-1:0] wb_bypass(
      input logic [XADDR-1:0] rs_addr,
      input logic [XLEN-1:0]  rf_data,
      input logic             wb_en,
      input logic [XADDR-1:0] wb_addr,
      input logic [XLEN-1:0]  wb_data
   );
      if (wb_en && (wb_addr != '0) && (rs_addr == wb_addr))
         return wb_data;
      return rf_data;
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the valid instruction currently in decode.
import id_ex_stage_pkg::*;

module hazard_detect (
   input  logic             ex_valid_i,
   input  logic             ex_mem_rd_en_i,
   input  logic [XADDR-1:0] ex_rd_addr_i,
   input  logic             id_valid_i,
   input  logic             id_uses_rs1_i,
   input  logic [XADDR-1:0] id_rs1_addr_i,
   input  logic             id_uses_rs2_i,
   input  logic [XADDR-1:0] id_rs2_addr_i,
   output logic             load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
   assign rs2_hit = id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);

   // x0 is never a real producer, so a load to x0 cannot create a dependency.
   assign load_use_o = ex_valid_i && ex_mem_rd_en_i && (ex_rd_addr_i != '0) &&
                       id_valid_i && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and WB bypass at capture.
// Optional CSR fields are built when ZICSR_EN is defined.
import id_ex_stage_pkg::*;

module id_ex_stage (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_valid_id,
   input  logic [XLEN-1:0]    i_pc_id,
   input  logic [XLEN-1:0]    i_imm_id,
   input  logic [XLEN-1:0]    i_rs1_id,
   input  logic [XLEN-1:0]    i_rs2_id,
   input  logic [XADDR-1:0]   i_rs1_addr_id,
   input  logic [XADDR-1:0]   i_rs2_addr_id,
   input  logic [XADDR-1:0]   i_rd_addr_id,
   input  logic               i_uses_rs1_id,
   input  logic               i_uses_rs2_id,
   input  logic [ALUOP_W-1:0] i_alu_op_id,
   input  logic               i_rd_wr_en_id,
   input  logic               i_mem_rd_en_id,
   input  logic               i_mem_wr_en_id,
   input  logic [XLEN-1:0]    i_rd_wb,
   input  logic [XADDR-1:0]   i_rd_addr_wb,
   input  logic               i_rd_wb_wr_en,
   input  logic               i_flush,
   input  logic               i_stall_ext,
`ifdef ZICSR_EN
   input  logic                  i_csr_en_id,
   input  logic [CSR_OP_W-1:0]   i_csr_op_id,
   input  logic [CSR_ADDR_W-1:0] i_csr_addr_id,
   output logic                  o_csr_en_ex,
   output logic [CSR_OP_W-1:0]   o_csr_op_ex,
   output logic [CSR_ADDR_W-1:0] o_csr_addr_ex,
`endif
   output logic               o_stall_id,
   output logic               o_valid_ex,
   output logic [XLEN-1:0]    o_pc_ex,
   output logic [XLEN-1:0]    o_imm_ex,
   output logic [XLEN-1:0]    o_rs1_ex,
   output logic [XLEN-1:0]    o_rs2_ex,
   output logic [XADDR-1:0]   o_rs1_addr_ex,
   output logic [XADDR-1:0]   o_rs2_addr_ex,
   output logic [XADDR-1:0]   o_rd_addr_ex,
   output logic [ALUOP_W-1:0] o_alu_op_ex,
   output logic               o_rd_wr_en_ex,
   output logic               o_mem_rd_en_ex,
   output logic               o_mem_wr_en_ex
);

   ex_regs_t ex_q;
   ex_regs_t ex_d;
   logic     load_use;

   hazard_detect u_hazard_detect (
      .ex_valid_i     (ex_q.valid),
      .ex_mem_rd_en_i (ex_q.mem_rd_en),
      .ex_rd_addr_i   (ex_q.rd_addr),
      .id_valid_i     (i_valid_id),
      .id_uses_rs1_i  (i_uses_rs1_id),
      .id_rs1_addr_i  (i_rs1_addr_id),
      .id_uses_rs2_i  (i_uses_rs2_id),
      .id_rs2_addr_i  (i_rs2_addr_id),
      .load_use_o     (load_use)
   );

   // A flush kills the dependent instruction anyway, so it needs no stall.
   assign o_stall_id = i_stall_ext || (load_use && !i_flush);

   always_comb begin
      ex_d = ex_q;
      if (!i_stall_ext) begin
         if (i_flush || load_use) begin
            // Bubble: only control is cleared, data fields are don't-care.
            ex_d.valid     = 1'b0;
            ex_d.rd_wr_en  = 1'b0;
            ex_d.mem_rd_en = 1'b0;
            ex_d.mem_wr_en = 1'b0;
`ifdef ZICSR_EN
            ex_d.csr_en    = 1'b0;
`endif
         end else begin
            ex_d.valid     = i_valid_id;
            ex_d.rd_wr_en  = i_valid_id && i_rd_wr_en_id && (i_rd_addr_id != '0);
            ex_d.mem_rd_en = i_valid_id && i_mem_rd_en_id;
            ex_d.mem_wr_en = i_valid_id && i_mem_wr_en_id;
`ifdef ZICSR_EN
            ex_d.csr_en    = i_valid_id && i_csr_en_id;
            ex_d.csr_op    = i_csr_op_id;
            ex_d.csr_addr  = i_csr_addr_id;
`endif
            ex_d.alu_op    = i_alu_op_id;
            ex_d.rs1_addr  = i_rs1_addr_id;
            ex_d.rs2_addr  = i_rs2_addr_id;
            ex_d.rd_addr   = i_rd_addr_id;
            ex_d.pc        = i_pc_id;
            ex_d.imm       = i_imm_id;
            ex_d.rs1       = wb_bypass(i_rs1_addr_id, i_rs1_id, i_rd_wb_wr_en,
                                       i_rd_addr_wb, i_rd_wb);
            ex_d.rs2       = wb_bypass(i_rs2_addr_id, i_rs2_id, i_rd_wb_wr_en,
                                       i_rd_addr_wb, i_rd_wb);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign o_valid_ex     = ex_q.valid;
   assign o_pc_ex        = ex_q.pc;
   assign o_imm_ex       = ex_q.imm;
   assign o_rs1_ex       = ex_q.rs1;
   assign o_rs2_ex       = ex_q.rs2;
   assign o_rs1_addr_ex  = ex_q.rs1_addr;
   assign o_rs2_addr_ex  = ex_q.rs2_addr;
   assign o_rd_addr_ex   = ex_q.rd_addr;
   assign o_alu_op_ex    = ex_q.alu_op;
   assign o_rd_wr_en_ex  = ex_q.rd_wr_en;
   assign o_mem_rd_en_ex = ex_q.mem_rd_en;
   assign o_mem_wr_en_ex = ex_q.mem_wr_en;
`ifdef ZICSR_EN
   assign o_csr_en_ex    = ex_q.csr_en;
   assign o_csr_op_ex    = ex_q.csr_op;
   assign o_csr_addr_ex  = ex_q.csr_addr;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, load-use stall, x0 guards,
// WB bypass, flush/stall priority, and CSR fields when ZICSR_EN is defined.
import id_ex_stage_pkg::*;

module tb_id_ex_stage;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               valid_id;
   logic [XLEN-1:0]    pc_id, imm_id, rs1_id, rs2_id;
   logic [XADDR-1:0]   rs1_addr_id, rs2_addr_id, rd_addr_id;
   logic               uses_rs1_id, uses_rs2_id;
   logic [ALUOP_W-1:0] alu_op_id;
   logic               rd_wr_en_id, mem_rd_en_id, mem_wr_en_id;
   logic [XLEN-1:0]    rd_wb;
   logic [XADDR-1:0]   rd_addr_wb;
   logic               rd_wb_wr_en;
   logic               flush, stall_ext;
   logic               stall_id;
   logic               valid_ex;
   logic [XLEN-1:0]    pc_ex, imm_ex, rs1_ex, rs2_ex;
   logic [XADDR-1:0]   rs1_addr_ex, rs2_addr_ex, rd_addr_ex;
   logic [ALUOP_W-1:0] alu_op_ex;
   logic               rd_wr_en_ex, mem_rd_en_ex, mem_wr_en_ex;
`ifdef ZICSR_EN
   logic                  csr_en_id, csr_en_ex;
   logic [CSR_OP_W-1:0]   csr_op_id, csr_op_ex;
   logic [CSR_ADDR_W-1:0] csr_addr_id, csr_addr_ex;
`endif

   int checks = 0;
   int errors = 0;

   id_ex_stage dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_valid_id     (valid_id),
      .i_pc_id        (pc_id),
      .i_imm_id       (imm_id),
      .i_rs1_id       (rs1_id),
      .i_rs2_id       (rs2_id),
      .i_rs1_addr_id  (rs1_addr_id),
      .i_rs2_addr_id  (rs2_addr_id),
      .i_rd_addr_id   (rd_addr_id),
      .i_uses_rs1_id  (uses_rs1_id),
      .i_uses_rs2_id  (uses_rs2_id),
      .i_alu_op_id    (alu_op_id),
      .i_rd_wr_en_id  (rd_wr_en_id),
      .i_mem_rd_en_id (mem_rd_en_id),
      .i_mem_wr_en_id (mem_wr_en_id),
      .i_rd_wb        (rd_wb),
      .i_rd_addr_wb   (rd_addr_wb),
      .i_rd_wb_wr_en  (rd_wb_wr_en),
      .i_flush        (flush),
      .i_stall_ext    (stall_ext),
`ifdef ZICSR_EN
      .i_csr_en_id    (csr_en_id),
      .i_csr_op_id    (csr_op_id),
      .i_csr_addr_id  (csr_addr_id),
      .o_csr_en_ex    (csr_en_ex),
      .o_csr_op_ex    (csr_op_ex),
      .o_csr_addr_ex  (csr_addr_ex),
`endif
      .o_stall_id     (stall_id),
      .o_valid_ex     (valid_ex),
      .o_pc_ex        (pc_ex),
      .o_imm_ex       (imm_ex),
      .o_rs1_ex       (rs1_ex),
      .o_rs2_ex       (rs2_ex),
      .o_rs1_addr_ex  (rs1_addr_ex),
      .o_rs2_addr_ex  (rs2_addr_ex),
      .o_rd_addr_ex   (rd_addr_ex),
      .o_alu_op_ex    (alu_op_ex),
      .o_rd_wr_en_ex  (rd_wr_en_ex),
      .o_mem_rd_en_ex (mem_rd_en_ex),
      .o_mem_wr_en_ex (mem_wr_en_ex)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %-14s got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %-14s 0x%08h", tag, obs);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic id_idle();
      valid_id = 0; pc_id = '0; imm_id = '0; rs1_id = '0; rs2_id = '0;
      rs1_addr_id = '0; rs2_addr_id = '0; rd_addr_id = '0;
      uses_rs1_id = 0; uses_rs2_id = 0; alu_op_id = '0;
      rd_wr_en_id = 0; mem_rd_en_id = 0; mem_wr_en_id = 0;
`ifdef ZICSR_EN
      csr_en_id = 0; csr_op_id = '0; csr_addr_id = '0;
`endif
   endtask

   // Drive a decoded instruction: rd, rs1, rs2 addresses and the load/store/writeback bits.
   task automatic id_instr(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1a,
                           input logic u1, input logic [4:0] rs2a, input logic u2,
                           input logic wr, input logic ld, input logic st);
      valid_id = 1; pc_id = pc; rd_addr_id = rd;
      rs1_addr_id = rs1a; uses_rs1_id = u1; rs2_addr_id = rs2a; uses_rs2_id = u2;
      rd_wr_en_id = wr; mem_rd_en_id = ld; mem_wr_en_id = st;
   endtask

   initial begin
      id_idle();
      rd_wb = '0; rd_addr_wb = '0; rd_wb_wr_en = 0;
      flush = 0; stall_ext = 0;
      rst_n = 0;

      // Reset state and stall pass-through during reset
      #12;
      check("rst_valid", 32'(valid_ex), 32'd0);
      check("rst_stall", 32'(stall_id), 32'd0);
      stall_ext = 1; #1;
      check("rst_stall_ext", 32'(stall_id), 32'd1);
      stall_ext = 0;
      step();
      rst_n = 1;

      // lw x5 into EX
      id_instr(32'h100, 5'd5, 5'd2, 1, 5'd0, 0, 1, 1, 0);
      step();
      check("lw_valid", 32'(valid_ex), 32'd1);
      check("lw_memrd", 32'(mem_rd_en_ex), 32'd1);
      check("lw_rd", 32'(rd_addr_ex), 32'd5);
      check("lw_pc", pc_ex, 32'h100);

      // add x6,x5,x1 in ID: one-cycle load-use stall then entry
      id_instr(32'h104, 5'd6, 5'd5, 1, 5'd1, 1, 1, 0, 0);
      rs1_id = 32'h11; rs2_id = 32'h22; alu_op_id = 4'h3;
      #1;
      check("lu_stall", 32'(stall_id), 32'd1);
      step();
      check("lu_bubble", 32'(valid_ex), 32'd0);
      check("lu_bub_wr", 32'(rd_wr_en_ex), 32'd0);
      check("lu_stall_off", 32'(stall_id), 32'd0);
      step();
      check("add_valid", 32'(valid_ex), 32'd1);
      check("add_pc", pc_ex, 32'h104);
      check("add_rs1", rs1_ex, 32'h11);
      check("add_rs2", rs2_ex, 32'h22);
      check("add_alu", 32'(alu_op_ex), 32'h3);

      // lw x0: rd write suppressed, and a reader of x0 does not stall
      id_instr(32'h108, 5'd0, 5'd1, 1, 5'd0, 0, 1, 1, 0);
      step();
      check("x0_wren", 32'(rd_wr_en_ex), 32'd0);
      check("x0_memrd", 32'(mem_rd_en_ex), 32'd1);
      id_instr(32'h10C, 5'd3, 5'd0, 1, 5'd0, 1, 1, 0, 0);
      #1;
      check("x0_nostall", 32'(stall_id), 32'd0);

      // Matching address but operand unused: no stall
      id_instr(32'h110, 5'd4, 5'd1, 1, 5'd0, 0, 1, 1, 0);
      step();
      id_instr(32'h114, 5'd6, 5'd4, 0, 5'd2, 1, 1, 0, 0);
      #1;
      check("unused_nostall", 32'(stall_id), 32'd0);
      // Same load in EX, dependency through rs2
      rs2_addr_id = 5'd4;
      #1;
      check("lu_rs2_stall", 32'(stall_id), 32'd1);
      id_idle();
      step();

      // WB bypass on rs2; a write to x0 is never bypassed
      id_instr(32'h120, 5'd9, 5'd0, 1, 5'd7, 1, 1, 0, 0);
      rs1_id = '0; rs2_id = '0;
      rd_wb = 32'hDEADBEEF; rd_addr_wb = 5'd7; rd_wb_wr_en = 1;
      step();
      check("byp_rs2", rs2_ex, 32'hDEADBEEF);
      check("byp_rs1_x0", rs1_ex, 32'h0);
      rd_wb = 32'h1234; rd_addr_wb = 5'd0;
      rs1_addr_id = 5'd0; rs1_id = 32'h0; rs2_addr_id = 5'd8; rs2_id = 32'h55;
      step();
      check("byp_x0", rs1_ex, 32'h0);
      check("byp_none", rs2_ex, 32'h55);
      rd_wb_wr_en = 0;

      // Flush together with load-use: bubble without stall
      id_instr(32'h200, 5'd9, 5'd1, 1, 5'd0, 0, 1, 1, 0);
      step();
      id_instr(32'h204, 5'd6, 5'd9, 1, 5'd0, 0, 1, 0, 0);
      flush = 1;
      #1;
      check("fl_lu_stall", 32'(stall_id), 32'd0);
      step();
      check("fl_valid", 32'(valid_ex), 32'd0);
      check("fl_wren", 32'(rd_wr_en_ex), 32'd0);
      flush = 0;
      step();
      check("post_fl_pc", pc_ex, 32'h204);
      check("post_fl_val", 32'(valid_ex), 32'd1);

      // External stall together with flush: hold, then flush after release
      id_instr(32'h300, 5'd2, 5'd0, 0, 5'd0, 0, 1, 0, 0);
      stall_ext = 1; flush = 1;
      #1;
      check("sx_stall", 32'(stall_id), 32'd1);
      step();
      check("sx_hold_pc", pc_ex, 32'h204);
      check("sx_hold_val", 32'(valid_ex), 32'd1);
      check("sx_hold_wr", 32'(rd_wr_en_ex), 32'd1);
      stall_ext = 0;
      step();
      check("sx_flush_val", 32'(valid_ex), 32'd0);
      flush = 0;

      // Invalid decode gates controls; a valid store passes through
      id_instr(32'h400, 5'd3, 5'd1, 1, 5'd2, 1, 1, 0, 1);
      valid_id = 0;
      step();
      check("inv_valid", 32'(valid_ex), 32'd0);
      check("inv_st", 32'(mem_wr_en_ex), 32'd0);
      check("inv_wr", 32'(rd_wr_en_ex), 32'd0);
      id_instr(32'h404, 5'd0, 5'd1, 1, 5'd2, 1, 0, 0, 1);
      imm_id = 32'hFFFF_FFF8; alu_op_id = 4'hA;
      step();
      check("st_en", 32'(mem_wr_en_ex), 32'd1);
      check("st_imm", imm_ex, 32'hFFFF_FFF8);
      check("st_alu", 32'(alu_op_ex), 32'hA);

`ifdef ZICSR_EN
      id_instr(32'h500, 5'd5, 5'd1, 1, 5'd0, 0, 1, 0, 0);
      csr_en_id = 1; csr_op_id = 3'd1; csr_addr_id = 12'h300;
      step();
      check("csr_en", 32'(csr_en_ex), 32'd1);
      check("csr_op", 32'(csr_op_ex), 32'd1);
      check("csr_addr", 32'(csr_addr_ex), 32'h300);
      flush = 1;
      step();
      check("csr_flush", 32'(csr_en_ex), 32'd0);
      flush = 0;
      id_idle();
`endif

      // Asynchronous reset during a load-use stall
      id_instr(32'h600, 5'd5, 5'd1, 1, 5'd0, 0, 1, 1, 0);
      step();
      id_instr(32'h604, 5'd6, 5'd5, 1, 5'd0, 0, 1, 0, 0);
      #1;
      check("pre_rst_stall", 32'(stall_id), 32'd1);
      #2;
      rst_n = 0;
      #1;
      check("arst_valid", 32'(valid_ex), 32'd0);
      check("arst_memrd", 32'(mem_rd_en_ex), 32'd0);
      check("arst_stall", 32'(stall_id), 32'd0);
      step();
      rst_n = 1;
      step();
      check("after_rst_pc", pc_ex, 32'h604);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
